// File: rtl/psum_collector.sv
// psum_collector: accumulates a configurable number of consecutive MAC psums
// into one signed result, optionally clamps negatives to zero, and queues the
// finished results in a small circular FIFO for the downstream writer.
module psum_collector #(
    parameter int bw         = 8,
    parameter int bw_psum    = 20,
    parameter int acc_bw     = bw_psum + 4,
    parameter int fifo_depth = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          cfg_len,
    input  logic                cfg_relu,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [bw_psum-1:0]  in_psum,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [acc_bw-1:0]   out_data,
    output logic                busy
);

    localparam int ptr_w = $clog2(fifo_depth);
    localparam int cnt_w = ptr_w + 1;

    // Reject parameter sets the datapath cannot support at elaboration time.
    if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0 ||
        acc_bw <= bw_psum || bw < 1) begin : g_bad_params
        $error("psum_collector: unsupported parameter combination");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [4:0]          idx_reg, idx_next;
    logic [4:0]          len_reg, len_next;
    logic                relu_reg, relu_next;
    logic [acc_bw-1:0]   acc_reg, acc_next;

    logic [ptr_w-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [cnt_w-1:0]    count_reg;
    logic [acc_bw-1:0]   slot_q [fifo_depth];

    logic [acc_bw-1:0]   psum_ext;
    logic [acc_bw-1:0]   sum;
    logic [acc_bw-1:0]   push_data;
    logic [4:0]          len_eff;
    logic [4:0]          idx_inc;
    logic                relu_eff;
    logic                last;
    logic                accept;
    logic                push;
    logic                pop;

    assign in_ready  = (count_reg != cnt_w'(fifo_depth));
    assign out_valid = (count_reg != '0);
    assign out_data  = slot_q[rd_ptr_reg];
    assign busy      = (idx_reg != 5'd0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && last;
    assign pop       = out_valid && out_ready;

    // Group arithmetic: the first psum of a group takes its length/ReLU from
    // the live config, later psums use the values latched at group start.
    always_comb begin
        psum_ext = {{(acc_bw - bw_psum){in_psum[bw_psum-1]}}, in_psum};
        if (state_reg == IDLE) begin
            len_eff  = (cfg_len == 4'd0) ? 5'd16 : {1'b0, cfg_len};
            relu_eff = cfg_relu;
            sum      = psum_ext;
        end else begin
            len_eff  = len_reg;
            relu_eff = relu_reg;
            sum      = acc_reg + psum_ext;
        end
        idx_inc   = idx_reg + 5'd1;
        last      = (idx_inc == len_eff);
        push_data = (relu_eff && sum[acc_bw-1]) ? '0 : sum;
    end

    // Next-state logic for the group FSM and its accumulator.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        len_next   = len_reg;
        relu_next  = relu_reg;
        acc_next   = acc_reg;
        if (accept) begin
            if (state_reg == IDLE) begin
                len_next  = len_eff;
                relu_next = relu_eff;
            end
            if (last) begin
                state_next = IDLE;
                idx_next   = 5'd0;
            end else begin
                state_next = ACCUM;
                idx_next   = idx_inc;
                acc_next   = sum;
            end
        end
    end

    // Group state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= 5'd0;
            len_reg   <= 5'd1;
            relu_reg  <= 1'b0;
            acc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            len_reg   <= len_next;
            relu_reg  <= relu_next;
            acc_reg   <= acc_next;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + ptr_w'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + cnt_w'(1);
                2'b01:   count_reg <= count_reg - cnt_w'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // FIFO storage: one register per slot so the head can be read combinationally.
    for (genvar gi = 0; gi < fifo_depth; gi++) begin : g_slot
        logic [acc_bw-1:0] slot_reg;

        // Capture the finished result when the write pointer selects this slot.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                slot_reg <= '0;
            end else if (push && (wr_ptr_reg == ptr_w'(gi))) begin
                slot_reg <= push_data;
            end
        end

        assign slot_q[gi] = slot_reg;
    end

endmodule

// File: tb/tb_psum_collector.sv
// Self-checking bench for psum_collector: directed table, hand-written corner
// sequences, and a randomized run against a group-level reference model.
module tb_psum_collector;

    localparam int NGROUPS = 30;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cfg_len;
    logic        cfg_relu;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_psum;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] len;
        logic       relu;
        int         psums[16];
        longint     exp;
    } vec_t;

    vec_t   tbl[7];
    longint exp_q[$];
    logic [3:0] rcfg[NGROUPS];
    logic       rrelu[NGROUPS];
    int         rps[NGROUPS][16];

    psum_collector #(
        .bw(8), .bw_psum(20), .acc_bw(24), .fifo_depth(4)
    ) dut (
        .clk(clk), .reset(reset), .cfg_len(cfg_len), .cfg_relu(cfg_relu),
        .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sdata();
        return longint'($signed(out_data));
    endfunction

    function automatic int eff_len(input logic [3:0] l);
        return (l == 4'd0) ? 16 : int'(l);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one psum and wait (bounded) until it is accepted.
    task automatic send(input int p);
        bit acc;
        int cyc;
        acc = 1'b0;
        cyc = 0;
        in_psum  = p[19:0];
        in_valid = 1'b1;
        while (!acc && cyc < 60) begin
            acc = in_ready;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: psum %0d not accepted after %0d cycles", p, cyc);
        end
    endtask

    initial begin
        // ---------------- directed table ----------------
        tbl[0].len = 4'd4; tbl[0].relu = 1'b0; tbl[0].exp = 60;
        tbl[0].psums[0] = 100; tbl[0].psums[1] = -50; tbl[0].psums[2] = 7; tbl[0].psums[3] = 3;
        tbl[1].len = 4'd2; tbl[1].relu = 1'b1; tbl[1].exp = 0;
        tbl[1].psums[0] = -300; tbl[1].psums[1] = 100;
        tbl[2].len = 4'd2; tbl[2].relu = 1'b0; tbl[2].exp = -200;
        tbl[2].psums[0] = -300; tbl[2].psums[1] = 100;
        tbl[3].len = 4'd0; tbl[3].relu = 1'b0; tbl[3].exp = 8388592;
        tbl[4].len = 4'd0; tbl[4].relu = 1'b1; tbl[4].exp = -8388608;
        tbl[4].relu = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tbl[3].psums[k] = 524287;
            tbl[4].psums[k] = -524288;
        end
        tbl[5].len = 4'd1; tbl[5].relu = 1'b1; tbl[5].exp = 0;  tbl[5].psums[0] = -5;
        tbl[6].len = 4'd1; tbl[6].relu = 1'b0; tbl[6].exp = -5; tbl[6].psums[0] = -5;

        // ---------------- reset state ----------------
        reset = 1'b1; cfg_len = 4'd1; cfg_relu = 1'b0;
        in_valid = 1'b0; in_psum = '0; out_ready = 1'b1;
        #12;
        chk("reset_in_ready", longint'(in_ready), 1);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_out_data", longint'(out_data), 0);
        chk("reset_busy", longint'(busy), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        step();

        // ---------------- table-driven groups ----------------
        for (int i = 0; i < 7; i++) begin
            int n;
            n = eff_len(tbl[i].len);
            for (int k = 0; k < n; k++) begin
                cfg_len  = (k == 0) ? tbl[i].len : 4'($urandom);
                cfg_relu = (k == 0) ? tbl[i].relu : 1'($urandom);
                send(tbl[i].psums[k]);
                if (k < n - 1) begin
                    chk("tbl_busy_mid", longint'(busy), 1);
                    chk("tbl_out_valid_mid", longint'(out_valid), 0);
                end else begin
                    chk("tbl_out_valid", longint'(out_valid), 1);
                    chk("tbl_result", sdata(), tbl[i].exp);
                    chk("tbl_busy_end", longint'(busy), 0);
                end
            end
            $display("table row %0d: len=%0d relu=%0d result=%0d expected=%0d",
                     i, n, tbl[i].relu, sdata(), tbl[i].exp);
        end
        step();
        chk("tbl_drained", longint'(out_valid), 0);

        // ---------------- mid-group config change and input stall ----------------
        cfg_len = 4'd3; cfg_relu = 1'b0;
        send(10);
        cfg_len = 4'd1; cfg_relu = 1'b1;
        repeat (5) step();
        chk("stall_busy", longint'(busy), 1);
        chk("stall_out_valid", longint'(out_valid), 0);
        send(20);
        chk("stall_busy2", longint'(busy), 1);
        send(30);
        chk("stall_out_valid_end", longint'(out_valid), 1);
        chk("stall_result", sdata(), 60);
        chk("stall_busy_end", longint'(busy), 0);
        cfg_relu = 1'b0;
        send(7);
        chk("next_len1_valid", longint'(out_valid), 1);
        chk("next_len1_result", sdata(), 7);
        chk("next_len1_busy", longint'(busy), 0);
        $display("config change: group 10+20+30 and len-1 group 7 done");
        step();

        // ---------------- FIFO full and back-pressure ----------------
        out_ready = 1'b0; cfg_len = 4'd1; cfg_relu = 1'b0;
        for (int v = 1; v <= 4; v++) send(v);
        chk("full_in_ready", longint'(in_ready), 0);
        chk("full_head", sdata(), 1);
        in_psum = 20'd5; in_valid = 1'b1;
        repeat (3) begin
            step();
            chk("full_stalled", longint'(in_ready), 0);
        end
        chk("full_head_hold", sdata(), 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pop_in_ready", longint'(in_ready), 1);
        chk("pop_head", sdata(), 2);
        step();
        in_valid = 1'b0;
        chk("refill_in_ready", longint'(in_ready), 0);
        out_ready = 1'b1;
        for (int v = 2; v <= 5; v++) begin
            chk("drain_valid", longint'(out_valid), 1);
            chk("drain_data", sdata(), v);
            $display("drain: got %0d expected %0d", sdata(), v);
            step();
        end
        chk("drain_empty", longint'(out_valid), 0);

        // ---------------- reset mid-operation ----------------
        out_ready = 1'b0; cfg_len = 4'd1;
        send(9);
        cfg_len = 4'd4;
        send(5);
        send(6);
        chk("prerst_busy", longint'(busy), 1);
        chk("prerst_valid", longint'(out_valid), 1);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_data", longint'(out_data), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        cfg_len = 4'd2; out_ready = 1'b1;
        send(1);
        chk("postrst_busy", longint'(busy), 1);
        send(1);
        chk("postrst_valid", longint'(out_valid), 1);
        chk("postrst_result", sdata(), 2);
        $display("reset recovery: result %0d expected 2", sdata());
        step();

        // ---------------- randomized run against group model ----------------
        for (int g = 0; g < NGROUPS; g++) begin
            longint s;
            rcfg[g]  = 4'($urandom);
            rrelu[g] = 1'($urandom);
            s = 0;
            for (int k = 0; k < eff_len(rcfg[g]); k++) begin
                logic signed [19:0] p;
                p = 20'($urandom);
                rps[g][k] = int'(p);
                s += longint'(p);
            end
            exp_q.push_back((rrelu[g] && s < 0) ? 0 : s);
        end

        fork
            begin
                for (int g = 0; g < NGROUPS; g++) begin
                    for (int k = 0; k < eff_len(rcfg[g]); k++) begin
                        repeat ($urandom_range(0, 2)) step();
                        cfg_len  = (k == 0) ? rcfg[g] : 4'($urandom);
                        cfg_relu = (k == 0) ? rrelu[g] : 1'($urandom);
                        send(rps[g][k]);
                    end
                end
            end
            begin
                int got;
                int cyc;
                longint e;
                got = 0;
                cyc = 0;
                while (got < NGROUPS && cyc < 20000) begin
                    out_ready = 1'($urandom);
                    if (out_valid && out_ready) begin
                        e = exp_q.pop_front();
                        chk("rand_result", sdata(), e);
                        $display("random result %0d: got %0d expected %0d", got, sdata(), e);
                        got++;
                    end
                    step();
                    cyc++;
                end
                if (got < NGROUPS) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_timeout: got %0d results expected %0d", got, NGROUPS);
                end
                out_ready = 1'b1;
            end
        join
        step();
        chk("rand_empty", longint'(out_valid), 0);
        chk("rand_idle", longint'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
